// File: rtl/fft_channel_arbiter.sv
// Round-robin arbiter sharing one FFT core between the left and right frame buffers.
// Define FFTARB_TIMEOUT_EN to include the RUN-state watchdog and the err_o pulse.
module fft_channel_arbiter #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned bw_tmo       = 16,
  parameter int unsigned TMO_CYCLES   = 40000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [1:0] req_i,
  input  logic       fft_done_i,
  output logic       fft_start_o,
  output logic       ch_sel_o,
  output logic       cgate_o,
  output logic [1:0] ack_o,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {StIdle, StSetup, StStart, StRun, StRelease} state_e;

  state_e     state_q, state_d;
  logic       fft_start_q, fft_start_d;
  logic       ch_sel_q, ch_sel_d;
  logic       cgate_q, cgate_d;
  logic [1:0] ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       last_ch_q, last_ch_d;
  logic [3:0] setup_cnt_q, setup_cnt_d;
  logic       grant_ch;

`ifdef FFTARB_TIMEOUT_EN
  logic [bw_tmo-1:0] wd_q, wd_d;
  logic              err_q, err_d;
  logic              tmo_hit;

  // Expire on the edge where the watchdog would step to TMO_CYCLES-1.
  assign tmo_hit = (wd_q == bw_tmo'(TMO_CYCLES - 2));
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

  // Single requester wins outright; a tie goes to the channel not served last.
  assign grant_ch = req_i[0] ? (req_i[1] & ~last_ch_q) : 1'b1;

  always_comb begin
    state_d     = state_q;
    fft_start_d = fft_start_q;
    ch_sel_d    = ch_sel_q;
    cgate_d     = cgate_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    last_ch_d   = last_ch_q;
    setup_cnt_d = setup_cnt_q;
`ifdef FFTARB_TIMEOUT_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable_i && (req_i != 2'b00)) begin
          ch_sel_d    = grant_ch;
          busy_d      = 1'b1;
          cgate_d     = 1'b0;
          setup_cnt_d = 4'd0;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        if (setup_cnt_q == 4'(SETUP_CYCLES - 1)) begin
          fft_start_d = 1'b1;
          state_d     = StStart;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      StStart: begin
        fft_start_d = 1'b0;
`ifdef FFTARB_TIMEOUT_EN
        wd_d        = '0;
`endif
        state_d     = StRun;
      end
      StRun: begin
        if (fft_done_i) begin
          ack_d   = ch_sel_q ? 2'b10 : 2'b01;
          cgate_d = 1'b1;
          state_d = StRelease;
        end
`ifdef FFTARB_TIMEOUT_EN
        else if (tmo_hit) begin
          ack_d   = ch_sel_q ? 2'b10 : 2'b01;
          cgate_d = 1'b1;
          err_d   = 1'b1;
          state_d = StRelease;
        end else begin
          wd_d = wd_q + bw_tmo'(1);
        end
`endif
      end
      StRelease: begin
        ack_d     = 2'b00;
        busy_d    = 1'b0;
        last_ch_d = ch_sel_q;
`ifdef FFTARB_TIMEOUT_EN
        err_d     = 1'b0;
`endif
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      fft_start_q <= 1'b0;
      ch_sel_q    <= 1'b0;
      cgate_q     <= 1'b1;
      ack_q       <= 2'b00;
      busy_q      <= 1'b0;
      last_ch_q   <= 1'b1;
      setup_cnt_q <= 4'd0;
`ifdef FFTARB_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fft_start_q <= fft_start_d;
      ch_sel_q    <= ch_sel_d;
      cgate_q     <= cgate_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      last_ch_q   <= last_ch_d;
      setup_cnt_q <= setup_cnt_d;
`ifdef FFTARB_TIMEOUT_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign fft_start_o = fft_start_q;
  assign ch_sel_o    = ch_sel_q;
  assign cgate_o     = cgate_q;
  assign ack_o       = ack_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fft_channel_arbiter.sv
// Scoreboard bench for fft_channel_arbiter: random requesters and FFT core, plus directed
// reset, watchdog (FFTARB_TIMEOUT_EN) and hang cases.
module tb_fft_channel_arbiter;
  localparam int unsigned SetupCycles = 2;
  localparam int unsigned TmoCycles   = 100;

  logic       clk, rst_n, enable, fft_done;
  logic [1:0] req;
  logic       fft_start, ch_sel, cgate, busy, err;
  logic [1:0] ack;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          exp_q[$];
  bit          mon_en = 1'b0;

  fft_channel_arbiter #(
    .SETUP_CYCLES(SetupCycles),
    .bw_tmo      (16),
    .TMO_CYCLES  (TmoCycles)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .req_i      (req),
    .fft_done_i (fft_done),
    .fft_start_o(fft_start),
    .ch_sel_o   (ch_sel),
    .cgate_o    (cgate),
    .ack_o      (ack),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference arbitration rule: lone requester wins, a tie goes to the one not served last.
  function automatic bit pick(input bit [1:0] p, input bit last);
    if (p == 2'b01) return 1'b0;
    if (p == 2'b10) return 1'b1;
    return ~last;
  endfunction

  task automatic wait_start(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fft_start && n < 40);
    ok = fft_start;
    if (!ok) check("start_timeout", 0, 1);
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  // Monitor: pops the expected channel at each grant and checks the grant's outputs.
  bit          busy_prev, start_prev, in_grant, cur_ch;
  int unsigned start_dist;
  always @(negedge clk) begin
    if (!mon_en) begin
      busy_prev  = 1'b0;
      start_prev = 1'b0;
      in_grant   = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        if (exp_q.size() == 0) check("grant_unexpected", 1, 0);
        else begin
          cur_ch = exp_q.pop_front();
          check("grant_ch", int'(ch_sel), int'(cur_ch));
        end
        check("grant_cgate", int'(cgate), 0);
        in_grant   = 1'b1;
        start_dist = 0;
      end else if (in_grant) start_dist++;
      if (fft_start) begin
        if (!in_grant) check("start_outside_grant", 1, 0);
        else if (start_prev) check("start_width", 2, 1);
        else check("start_latency", int'(start_dist), int'(SetupCycles));
      end
      if (ack != 2'b00) begin
        if (!in_grant) check("ack_unexpected", int'(ack), 0);
        else begin
          check("ack_ch", int'(ack), cur_ch ? 2 : 1);
          check("ack_err", int'(err), 0);
          check("ack_cgate", int'(cgate), 1);
          in_grant = 1'b0;
        end
      end
      busy_prev  = busy;
      start_prev = fft_start;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit [1:0] pending;
    bit       last_srv, gch, ok, aborted;
    int       frames, n, bad;

    rst_n = 1'b0; req = 2'b00; enable = 1'b1; fft_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cgate", int'(cgate), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_start", int'(fft_start), 0);
    check("rst_err", int'(err), 0);
    check("rst_chsel", int'(ch_sel), 0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || !cgate || ack != 2'b00 || fft_start || err) bad++;
    end
    check("idle_hold", bad, 0);

    // Random phase: requesters drop on their Ack, core answers after a random delay.
    mon_en = 1'b1;
    last_srv = 1'b1; pending = 2'b00; frames = 0; aborted = 1'b0;
    while (!aborted && (frames < 40 || pending != 2'b00)) begin
      if (pending == 2'b00) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 2) == 0) pulse_done();
        pending = (frames == 0) ? 2'b11 : 2'($urandom_range(1, 3));
        exp_q.push_back(pick(pending, last_srv));
        if (frames != 0 && $urandom_range(0, 3) == 0) begin
          enable = 1'b0;
          req = pending;
          repeat ($urandom_range(5, 15)) @(negedge clk);
          check("enable_gate", int'(busy), 0);
          enable = 1'b1;
        end else req = pending;
      end
      gch = pick(pending, last_srv);
      wait_start(ok);
      if (!ok) begin
        aborted = 1'b1;
        break;
      end
      if (frames < 38 && $urandom_range(0, 1) == 1) begin
        pending[~gch] = 1'b1;
        req = pending;
      end
      if ($urandom_range(0, 3) == 0) enable = 1'b0;
      repeat (1 + $urandom_range(0, 20)) @(negedge clk);
      pulse_done();
      n = 0;
      while (ack == 2'b00 && n < 4) begin
        @(negedge clk);
        n++;
      end
      if (ack == 2'b00) begin
        check("ack_timeout", 0, 1);
        aborted = 1'b1;
        break;
      end
      pending[gch] = 1'b0;
      req = pending;
      last_srv = gch;
      enable = 1'b1;
      frames++;
      if (pending != 2'b00) exp_q.push_back(pick(pending, last_srv));
    end
    req = 2'b00;
    repeat (4) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    mon_en = 1'b0;
    @(negedge clk);

`ifdef FFTARB_TIMEOUT_EN
    req = 2'b10;
    wait_start(ok);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < int'(TmoCycles) + 10);
    check("wdog_latency", n, int'(TmoCycles));
    check("wdog_err", int'(err), 1);
    check("wdog_ack", int'(ack), 2);
    check("wdog_cgate", int'(cgate), 1);
    req = 2'b00;
    @(negedge clk);
    check("wdog_err_width", int'(err), 0);
    repeat (3) @(negedge clk);
    req = 2'b10;
    wait_start(ok);
    repeat (TmoCycles - 1) @(negedge clk);
    pulse_done();
    check("done_wins_ack", int'(ack), 2);
    check("done_wins_err", int'(err), 0);
`else
    req = 2'b10;
    wait_start(ok);
    repeat (150) @(negedge clk);
    check("hang_ack", int'(ack), 0);
    check("hang_err", int'(err), 0);
    check("hang_busy", int'(busy), 1);
    pulse_done();
    check("hang_done_ack", int'(ack), 2);
`endif
    req = 2'b00;
    repeat (4) @(negedge clk);

    // Reset while RUN, then a stale done from the core must not be acknowledged.
    req = 2'b01;
    wait_start(ok);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cgate", int'(cgate), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ack", int'(ack), 0);
    check("mid_rst_start", int'(fft_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_done();
    check("late_done_ack", int'(ack), 0);
    check("regrant_busy", int'(busy), 1);
    wait_start(ok);
    check("regrant_chsel", int'(ch_sel), 0);
    repeat (2) @(negedge clk);
    pulse_done();
    check("regrant_ack", int'(ack), 1);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("final_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_channel_arbiter.md
Name: fft_channel_arbiter

Overview:
- Shares the single FFT core between the left and right channel frame buffers of the stereo analyzer.
- Accepts a level request from each channel and grants the core round-robin.
- For each grant it drives channel select, the FFT clock gate and a one-cycle start pulse, then waits for the core's done pulse and acknowledges the requester.
- Sits between the two frame-buffer writers and the FFT core/sequencer.

Parameters:
- SETUP_CYCLES, 2: cycles between a grant and FFT_Start, letting the ChSel-driven input mux and coefficient registers settle; legal range 1..15.
- bw_tmo, 16: width of the watchdog counter.
- TMO_CYCLES, 40000: watchdog limit in clocks, counted from FFT_Start; must be < 2^bw_tmo.

Ports:
- Clock    input   1  single system clock, rising edge.
- Reset_n  input   1  asynchronous, active-low reset.
- Enable   input   1  high = new grants allowed.
- Req      input   2  [0]=L, [1]=R; level, held until Ack.
- FFT_Done input   1  one-cycle pulse from the FFT core when a frame completes.
- FFT_Start output 1  one-cycle start pulse to the FFT core.
- ChSel    output  1  selected channel, 0=L, 1=R; stable for the whole grant.
- CGate    output  1  FFT clock gate; high = clock stopped.
- Ack      output  2  one-cycle completion pulse to the granted requester.
- Busy     output  1  high from grant until return to IDLE.
- Err      output  1  one-cycle pulse on watchdog expiry.

Behaviour:
- All outputs are registered.
- Reset values: FFT_Start=0, ChSel=0, CGate=1, Ack=2'b00, Busy=0, Err=0.
- Reset internals: state=IDLE, LastCh=1 (so L wins the first tie), counters=0.
- An asserted Reset_n mid-operation aborts immediately. No Ack is issued; requesters must retry.
- States: IDLE, SETUP, START, RUN, RELEASE.
- IDLE:
  - Grant when Enable=1 and Req!=0.
  - Selection: only one bit set → that channel. Both set → ~LastCh (round-robin).
  - On the grant edge: ChSel<=selected, Busy<=1, CGate<=0, setup counter<=0, go to SETUP.
- SETUP:
  - Counter increments each cycle.
  - When counter==SETUP_CYCLES-1: go to START and set FFT_Start<=1.
  - Latency: with Req sampled at edge k, FFT_Start is high in the cycle after edge k+SETUP_CYCLES.
- START:
  - FFT_Start<=0, watchdog<=0, go to RUN.
- RUN:
  - Watchdog increments each cycle.
  - FFT_Done=1 → go to RELEASE with Ack[ChSel]<=1 and CGate<=1.
  - Watchdog reaching TMO_CYCLES-1 without Done → go to RELEASE with Err<=1, Ack[ChSel]<=1, CGate<=1.
  - Done and expiry on the same cycle: Done wins, Err stays 0.
- RELEASE:
  - Ack<=0, Err<=0, Busy<=0, LastCh<=ChSel, go to IDLE.
  - ChSel holds its value until the next grant.
- Requester rule: Req[i] must drop on the edge that samples Ack[i]=1. IDLE therefore never re-grants a just-served request.
- FFT_Done outside RUN is ignored.
- Req changes during a grant are ignored. The pending request is served on the next IDLE cycle.
- Enable=0 blocks grants in IDLE only; a grant in progress runs to RELEASE normally.
- Back-to-back operation: with both Req held, grants alternate L,R,L,R. Minimum gap is one IDLE cycle between RELEASE and the next SETUP.
- Counters never wrap. The setup counter is 4-bit and the watchdog is bw_tmo bits, both bounded by their compare values.

Optional Feature:
- Macro: FFTARB_TIMEOUT_EN.
- Defined: the watchdog operates as described above and Err can pulse.
- Undefined:
  - No watchdog counter; RUN waits indefinitely for FFT_Done.
  - Err is tied to 0; TMO_CYCLES and bw_tmo are unused.
  - Recovery from a hung core is by Reset_n only.

Test Plan:
- Reset then idle: Reset_n=0 → CGate=1, Busy=0, Ack=00, FFT_Start=0. Release reset with Req=00 → outputs stay at reset values for 20 cycles.
- Single L request (SETUP_CYCLES=2): Req=01 sampled at edge k → ChSel=0, Busy=1, CGate=0 after edge k; FFT_Start high only after edge k+2. Done pulsed at edge d → Ack=01 for exactly one cycle after edge d, CGate=1; Busy=0 after edge d+1.
- Simultaneous requests after reset: Req=11 held, requesters dropping on their Ack → grants ordered L,R, then L again when L re-requests. ChSel sequence 0,1,0; no FFT_Start overlaps an unfinished grant.
- Enable gating: Enable=0 with Req=10 → no grant for 50 cycles. Deassert Enable mid-RUN → the current frame still completes with Ack. Enable=1 → R granted.
- Watchdog (FFTARB_TIMEOUT_EN, TMO_CYCLES=100): FFT_Done never pulsed → Err and Ack[ChSel] pulse together 100 cycles after FFT_Start, CGate=1. Same test with Done on cycle 100 → Err=0.
- Reset mid-RUN: Reset_n low while in RUN → immediate CGate=1, Busy=0, no Ack. After release, pending Req=01 is re-granted normally, and a late FFT_Done from the core is ignored.
